vga_draw_arbiter: RTL and testbench
===================================

// Module: vga_draw_arbiter
// PURPOSE
//   N-channel arbiter feeding the single VGA adapter port (x, y, colour, plot). Sprite and background
//   drawers each present pixel streams over a valid/ready handshake.
//   Grants one channel at a time and holds the grant for a whole burst (sprite/tile) until the pixel
//   marked last. Registers the chosen pixel into the adapter interface. Replaces the fixed 2-way
//   background/pac-man select with parametrised channel count, fixed or round-robin priority, burst
//   locking, a fairness cap and back-pressure.
// PARAMETERS
//   NUM_CH     4   number of drawing channels (>=2); channel 0 = background by convention
//   X_W        8   x coordinate width
//   Y_W        7   y coordinate width
//   COLOUR_W   3   colour width
//   RR_MODE    1   0 = fixed priority (lowest index wins), 1 = round-robin
//   MAX_BURST  0   max pixels per grant before forced release; 0 = unlimited
// PORTS
//   clock       in   1               system clock, all state on rising edge
//   resetn      in   1               asynchronous active-low reset
//   req_valid   in   NUM_CH          per-channel pixel valid
//   req_last    in   NUM_CH          per-channel: this pixel ends the burst
//   req_x       in   NUM_CH*X_W      packed x, channel i at [i*X_W +: X_W]
//   req_y       in   NUM_CH*Y_W      packed y, same packing
//   req_colour  in   NUM_CH*COLOUR_W packed colour, same packing
//   req_ready   out  NUM_CH          per-channel pixel accepted this cycle when valid&ready
//   vga_ready   in   1               adapter can take a pixel (tie 1 for plain adapter)
//   vga_x       out  X_W             registered pixel x
//   vga_y       out  Y_W             registered pixel y
//   vga_colour  out  COLOUR_W        registered pixel colour
//   vga_plot    out  1               pixel valid / writeEn to adapter
//   grant_id    out  clog2(NUM_CH)   currently/last granted channel
//   busy        out  1               1 while in BURST
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE, vga_x/y/colour=0, vga_plot=0, req_ready=0, grant_id=0,
//     busy=0, rr_ptr=0, burst_cnt=0. Asserting reset mid-burst drops any pending pixel.
//   FSM IDLE: req_ready=0.
//     - If any req_valid, pick winner and register grant_id. Fixed priority picks the lowest set
//       index. RR_MODE picks the first set index searching upward from rr_ptr with wrap.
//     - Go to BURST next cycle. No valid -> stay.
//   FSM BURST: req_ready[grant_id] = (!vga_plot | vga_ready); all other req_ready bits = 0.
//     - Handshake = req_valid[g] & req_ready[g]. On handshake, the channel's x/y/colour load into the
//       vga_* registers and vga_plot=1 the following cycle.
//     - Latency: pixel handshaken in cycle t appears on vga_* in cycle t+1.
//     - Output hold: while vga_plot=1 & vga_ready=0, vga_* stay stable and no new pixel is accepted.
//     - vga_plot clears when vga_ready=1 and no new handshake occurs in that cycle.
//     - burst_cnt increments per handshake, width clog2(MAX_BURST+1), cleared on grant.
//     - Release -> IDLE when the handshake has req_last=1, or when MAX_BURST!=0 and the handshake
//       makes burst_cnt==MAX_BURST.
//     - On release, rr_ptr = (grant_id+1) mod NUM_CH. In fixed mode rr_ptr is unused.
//     - A forced-release channel re-arbitrates normally; its burst continues in a later grant.
//   Granted channel deasserting valid mid-burst: grant held, no timeout, burst_cnt frozen.
//   Arbitration gap: exactly one IDLE cycle between consecutive bursts.
//   Non-granted channels' request inputs are ignored; they must hold valid and data until served.
//   Simultaneous last and forced-release on the same handshake: single release, rr_ptr advances once.
//   grant_id holds its value in IDLE until the next grant.
// TESTING
//   1. Reset: resetn=0 mid-burst -> vga_plot=0, all req_ready=0, busy=0 asynchronously, before the
//      next edge.
//   2. Single channel 2: 3-pixel burst (10,5,c3)..(12,5,c3), last on third, vga_ready=1.
//      -> grant_id=2; plots on 3 consecutive cycles one cycle after each handshake; then IDLE.
//   3. RR_MODE=1: ch0 and ch1 both request 1-pixel bursts continuously.
//      -> grants alternate 0,1,0,1 with one gap cycle between bursts.
//   4. RR_MODE=0, same stimulus as scenario 3 -> ch0 always wins, ch1 starved.
//   5. Back-pressure: vga_ready=0 for 4 cycles with pixel (7,3,5) latched.
//      -> vga_* stable at (7,3,5) and vga_plot=1 throughout; req_ready=0; next pixel accepted the
//         cycle vga_ready returns to 1.
//   6. MAX_BURST=4: ch1 sends 6 pixels with no last, ch3 also requesting.
//      -> release after the 4th pixel; ch3 granted; ch1 resumes in a later grant with pixels 5-6.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: N-channel pixel arbiter feeding a single VGA adapter port.
// Grants one drawer per burst (until last or MAX_BURST), registers pixels out.
//
// Ports:
//   clock, resetn               clock and async active-low reset
//   req_valid/last/ready        per-channel handshake, one bit per channel
//   req_x/y/colour              packed per-channel pixel, channel i at [i*W +: W]
//   vga_ready                   adapter can take a pixel
//   vga_x/y/colour, vga_plot    registered pixel and write enable
//   grant_id, busy              current/last grant, high while a burst is open
module vga_draw_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int RR_MODE   = 1,
    parameter int MAX_BURST = 0
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_last,
    input  logic [NUM_CH*X_W-1:0]        req_x,
    input  logic [NUM_CH*Y_W-1:0]        req_y,
    input  logic [NUM_CH*COLOUR_W-1:0]   req_colour,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic                         vga_ready,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic [$clog2(NUM_CH)-1:0]    grant_id,
    output logic                         busy
);

    localparam int GID_W = $clog2(NUM_CH);
    // MAX_BURST=0 would give a zero-width counter; keep one bit.
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   burst_cnt;
    logic [GID_W-1:0]   win;
    logic               win_found;
    int                 idx;
    logic               slot_free;
    logic               hs;
    logic               max_hit;
    logic               release_ev;
    logic               grant_ev;

    // Output register can take a new pixel when empty or being drained.
    assign slot_free = !vga_plot || vga_ready;
    assign hs        = (state == BURST) && req_valid[grant_id] && slot_free;
    assign max_hit   = (MAX_BURST != 0) &&
                       ((burst_cnt + 1'b1) == CNT_W'(MAX_BURST));
    assign release_ev = hs && (req_last[grant_id] || max_hit);
    assign grant_ev   = (state == IDLE) && (|req_valid);

    // Winner search: upward from rr_ptr with wrap, or from 0 when fixed.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                idx = (int'(rr_ptr) + k) % NUM_CH;
            end else begin
                idx = k;
            end
            if (!win_found && req_valid[idx]) begin
                win       = GID_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_ev)   state_nxt = BURST;
            BURST:   if (release_ev) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state == BURST);
        if (state == BURST) begin
            req_ready[grant_id] = slot_free;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            if (grant_ev) begin
                grant_id  <= win;
                burst_cnt <= '0;
            end else if (hs) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (release_ev) begin
                if (grant_id == GID_W'(NUM_CH - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_id + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (hs) begin
            vga_x      <= req_x[grant_id*X_W +: X_W];
            vga_y      <= req_y[grant_id*Y_W +: Y_W];
            vga_colour <= req_colour[grant_id*COLOUR_W +: COLOUR_W];
            vga_plot   <= 1'b1;
        end else if (vga_ready) begin
            vga_plot   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: round-robin/MAX_BURST=4 and fixed-priority
// instances share one set of request inputs.
module tb_vga_draw_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic        vga_ready;
    logic [7:0]  cx [4];
    logic [6:0]  cy [4];
    logic [2:0]  cc [4];

    logic [3:0]  r_rdy, f_rdy;
    logic [7:0]  r_x, f_x;
    logic [6:0]  r_y, f_y;
    logic [2:0]  r_c, f_c;
    logic        r_plot, f_plot;
    logic [1:0]  r_gid, f_gid;
    logic        r_busy, f_busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always_comb begin
        req_x      = {cx[3], cx[2], cx[1], cx[0]};
        req_y      = {cy[3], cy[2], cy[1], cy[0]};
        req_colour = {cc[3], cc[2], cc[1], cc[0]};
    end

    vga_draw_arbiter #(.RR_MODE(1), .MAX_BURST(4)) u_rr (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(r_rdy), .vga_ready(vga_ready),
        .vga_x(r_x), .vga_y(r_y), .vga_colour(r_c),
        .vga_plot(r_plot), .grant_id(r_gid), .busy(r_busy)
    );

    vga_draw_arbiter #(.RR_MODE(0), .MAX_BURST(0)) u_fx (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(f_rdy), .vga_ready(vga_ready),
        .vga_x(f_x), .vga_y(f_y), .vga_colour(f_c),
        .vga_plot(f_plot), .grant_id(f_gid), .busy(f_busy)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       vr;
        logic [3:0] e_rdy;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        logic [1:0] e_gid;
        logic       e_busy;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic vr);
        req_valid = v;
        req_last  = l;
        vga_ready = vr;
        for (int i = 0; i < 4; i++) begin
            cx[i] = x;
            cy[i] = y;
            cc[i] = c;
        end
    endtask

    task automatic rst_pulse();
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
    endtask

    int          n1;
    logic        p3;
    int          nhs;
    logic        prev_hs;
    logic [7:0]  prev_x;
    int          hs_cyc [8];
    int          hs_ch  [8];
    int          hs_x   [8];
    int          e_cyc  [7];
    int          e_ch   [7];
    int          e_xv   [7];

    initial begin
        tv[0]  = '{4'b0100, 4'b0000, 8'd10, 7'd5, 3'd3, 1'b1, 4'b0000, 1'b0, 8'd0,  7'd0, 3'd0, 2'd0, 1'b0};
        tv[1]  = '{4'b0100, 4'b0000, 8'd10, 7'd5, 3'd3, 1'b1, 4'b0100, 1'b0, 8'd0,  7'd0, 3'd0, 2'd2, 1'b1};
        tv[2]  = '{4'b0100, 4'b0000, 8'd11, 7'd5, 3'd3, 1'b1, 4'b0100, 1'b1, 8'd10, 7'd5, 3'd3, 2'd2, 1'b1};
        tv[3]  = '{4'b0100, 4'b0100, 8'd12, 7'd5, 3'd3, 1'b1, 4'b0100, 1'b1, 8'd11, 7'd5, 3'd3, 2'd2, 1'b1};
        tv[4]  = '{4'b0000, 4'b0000, 8'd0,  7'd0, 3'd0, 1'b1, 4'b0000, 1'b1, 8'd12, 7'd5, 3'd3, 2'd2, 1'b0};
        tv[5]  = '{4'b0000, 4'b0000, 8'd0,  7'd0, 3'd0, 1'b1, 4'b0000, 1'b0, 8'd12, 7'd5, 3'd3, 2'd2, 1'b0};
        tv[6]  = '{4'b0010, 4'b0000, 8'd7,  7'd3, 3'd5, 1'b1, 4'b0000, 1'b0, 8'd12, 7'd5, 3'd3, 2'd2, 1'b0};
        tv[7]  = '{4'b0010, 4'b0000, 8'd7,  7'd3, 3'd5, 1'b1, 4'b0010, 1'b0, 8'd12, 7'd5, 3'd3, 2'd1, 1'b1};
        tv[8]  = '{4'b0010, 4'b0010, 8'd8,  7'd3, 3'd6, 1'b0, 4'b0000, 1'b1, 8'd7,  7'd3, 3'd5, 2'd1, 1'b1};
        tv[9]  = tv[8];
        tv[10] = tv[8];
        tv[11] = tv[8];
        tv[12] = '{4'b0010, 4'b0010, 8'd8,  7'd3, 3'd6, 1'b1, 4'b0010, 1'b1, 8'd7,  7'd3, 3'd5, 2'd1, 1'b1};
        tv[13] = '{4'b0000, 4'b0000, 8'd0,  7'd0, 3'd0, 1'b1, 4'b0000, 1'b1, 8'd8,  7'd3, 3'd6, 2'd1, 1'b0};
        tv[14] = '{4'b0000, 4'b0000, 8'd0,  7'd0, 3'd0, 1'b1, 4'b0000, 1'b0, 8'd8,  7'd3, 3'd6, 2'd1, 1'b0};

        e_cyc = '{1, 2, 3, 4, 6, 8, 9};
        e_ch  = '{1, 1, 1, 1, 3, 1, 1};
        e_xv  = '{1, 2, 3, 4, 100, 5, 6};

        resetn = 1'b0;
        drive(4'b0000, 4'b0000, 8'd0, 7'd0, 3'd0, 1'b1);
        repeat (2) @(negedge clock);
        chk("rst_rr", {r_rdy, r_plot, r_x, r_y, r_c, r_gid, r_busy}, 32'd0);
        chk("rst_fx", {f_rdy, f_plot, f_x, f_y, f_c, f_gid, f_busy}, 32'd0);
        resetn = 1'b1;

        // Single-channel burst then back-pressure hold, one row per cycle.
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].v, tv[i].l, tv[i].x, tv[i].y, tv[i].c, tv[i].vr);
            #1;
            chk($sformatf("vec[%0d]", i),
                {r_rdy, r_plot, r_x, r_y, r_c, r_gid, r_busy},
                {tv[i].e_rdy, tv[i].e_plot, tv[i].e_x, tv[i].e_y,
                 tv[i].e_c, tv[i].e_gid, tv[i].e_busy});
            @(negedge clock);
        end

        // ch0 and ch1 request single-pixel bursts continuously.
        rst_pulse();
        drive(4'b0011, 4'b0011, 8'd1, 7'd1, 3'd1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 1) begin
                chk($sformatf("rr_busy[%0d]", k), r_busy, 1);
                chk($sformatf("rr_gid[%0d]", k), r_gid, ((k - 1) / 2) % 2);
                chk($sformatf("rr_rdy[%0d]", k), r_rdy,
                    (((k - 1) / 2) % 2 == 0) ? 4'b0001 : 4'b0010);
                chk($sformatf("fx_busy[%0d]", k), f_busy, 1);
                chk($sformatf("fx_gid[%0d]", k), f_gid, 0);
            end else begin
                chk($sformatf("rr_gap[%0d]", k), r_busy, 0);
                chk($sformatf("fx_gap[%0d]", k), f_busy, 0);
            end
            chk($sformatf("fx_starve[%0d]", k), f_rdy[1], 0);
            @(negedge clock);
        end

        // MAX_BURST=4: ch1 sends 6 pixels without last, ch3 competes.
        rst_pulse();
        drive(4'b0000, 4'b0000, 8'd0, 7'd9, 3'd2, 1'b1);
        n1 = 1;
        p3 = 1'b1;
        nhs = 0;
        prev_hs = 1'b0;
        prev_x = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            req_valid = {p3, 1'b0, (n1 <= 6), 1'b0};
            req_last  = {1'b1, 1'b0, (n1 == 6), 1'b0};
            cx[1] = 8'(n1);
            cx[3] = 8'd100;
            #1;
            if (prev_hs) begin
                chk($sformatf("s6_vx[%0d]", cyc), r_x, prev_x);
                chk($sformatf("s6_plot[%0d]", cyc), r_plot, 1);
            end
            prev_hs = 1'b0;
            if (req_valid[1] && r_rdy[1] && nhs < 8) begin
                hs_cyc[nhs] = cyc; hs_ch[nhs] = 1; hs_x[nhs] = n1;
                nhs++; prev_hs = 1'b1; prev_x = 8'(n1);
            end
            if (req_valid[3] && r_rdy[3] && nhs < 8) begin
                hs_cyc[nhs] = cyc; hs_ch[nhs] = 3; hs_x[nhs] = 100;
                nhs++; prev_hs = 1'b1; prev_x = 8'd100;
            end
            @(negedge clock);
            if (prev_hs && prev_x != 8'd100) n1++;
            if (prev_hs && prev_x == 8'd100) p3 = 1'b0;
        end
        chk("s6_count", nhs, 7);
        for (int j = 0; j < 7; j++) begin
            if (j < nhs) begin
                chk($sformatf("s6_hs[%0d]", j),
                    {8'(hs_cyc[j]), 8'(hs_ch[j]), 8'(hs_x[j])},
                    {8'(e_cyc[j]), 8'(e_ch[j]), 8'(e_xv[j])});
            end
        end

        // Reset asserted mid-burst with a pixel held by back-pressure.
        rst_pulse();
        drive(4'b0100, 4'b0000, 8'd33, 7'd4, 3'd7, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        chk("mid_pre", {r_plot, r_busy, r_x}, {1'b1, 1'b1, 8'd33});
        resetn = 1'b0;
        #1;
        chk("mid_rst_rr", {r_rdy, r_plot, r_busy, r_gid, r_x}, 32'd0);
        chk("mid_rst_fx", {f_rdy, f_plot, f_busy, f_gid, f_x}, 32'd0);
        drive(4'b0000, 4'b0000, 8'd0, 7'd0, 3'd0, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
